// File: rtl/exu_wb_ctrl.sv
// Execute/write-back sequencer: owns the GPR write port, issues one memory request
// per load/store, extends load data. Optional memory timeout: GPR_WB_TIMEOUT_EN.
module exu_wb_ctrl #(
  parameter int ISA_WIDTH      = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_wb_en,
  input  logic [GPR_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_mem_r,
  input  logic                      in_mem_w,
  input  logic [2:0]                in_ld_size,
  input  logic [ISA_WIDTH-1:0]      in_alu_result,
  input  logic [ISA_WIDTH-1:0]      in_st_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_we,
  output logic [ISA_WIDTH-1:0]      mem_req_addr,
  output logic [ISA_WIDTH-1:0]      mem_req_wdata,
  input  logic                      mem_resp_valid,
  input  logic [ISA_WIDTH-1:0]      mem_resp_rdata,
  output logic                      gpr_we,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [ISA_WIDTH-1:0]      gpr_wdata,
  output logic                      commit,
  output logic                      mem_err,
  output logic                      busy
);

  // state | meaning
  // IDLE  | waiting for an instruction, in_ready=1
  // MREQ  | memory request presented until mem_req_ready
  // MRESP | load issued, waiting for mem_resp_valid
  // WB    | single write-back/commit cycle
  typedef enum logic [1:0] {IDLE, MREQ, MRESP, WB} state_t;

  state_t state, state_nxt;

  logic                      wb_en_q;
  logic [GPR_ADDR_WIDTH-1:0] rd_q;
  logic                      load_q;
  logic                      store_q;
  logic [2:0]                size_q;
  logic [ISA_WIDTH-1:0]      alu_q;
  logic [ISA_WIDTH-1:0]      st_q;
  logic [ISA_WIDTH-1:0]      ld_data_q;
  logic [ISA_WIDTH-1:0]      ld_ext;
  logic                      accept, req_hs, resp_hs, to_hit, to_flag;

  assign accept  = in_valid && (state == IDLE);
  assign req_hs  = (state == MREQ) && mem_req_ready;
  assign resp_hs = (state == MRESP) && mem_resp_valid;

`ifdef GPR_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  assign to_hit = ((state == MREQ) || (state == MRESP)) && !req_hs && !resp_hs &&
                  (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (accept) to_cnt <= '0;
      else if ((state == MREQ) || (state == MRESP)) to_cnt <= to_cnt + 1'b1;
      if (accept) to_flag <= 1'b0;
      else if (to_hit) to_flag <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign to_flag = 1'b0;
`endif

  // ld/lwu only exist on a 64-bit datapath; everything unsupported writes 0
  always_comb begin
    ld_ext = '0;
    case (size_q)
      3'b000: ld_ext = ISA_WIDTH'($signed(mem_resp_rdata[7:0]));
      3'b001: ld_ext = ISA_WIDTH'($signed(mem_resp_rdata[15:0]));
      3'b010: ld_ext = ISA_WIDTH'($signed(mem_resp_rdata[31:0]));
      3'b100: ld_ext = ISA_WIDTH'(mem_resp_rdata[7:0]);
      3'b101: ld_ext = ISA_WIDTH'(mem_resp_rdata[15:0]);
      3'b110: if (ISA_WIDTH == 64) ld_ext = ISA_WIDTH'(mem_resp_rdata[31:0]);
      3'b011: if (ISA_WIDTH == 64) ld_ext = mem_resp_rdata;
      default: ld_ext = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (in_mem_r || in_mem_w) ? MREQ : WB;
      MREQ:  if (req_hs) state_nxt = store_q ? WB : MRESP;
             else if (to_hit) state_nxt = WB;
      MRESP: if (resp_hs || to_hit) state_nxt = WB;
      WB:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wb_en_q   <= 1'b0;
      rd_q      <= '0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      size_q    <= '0;
      alu_q     <= '0;
      st_q      <= '0;
      ld_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wb_en_q <= in_wb_en;
        rd_q    <= in_rd;
        load_q  <= in_mem_r;
        store_q <= in_mem_w && !in_mem_r;
        size_q  <= in_ld_size;
        alu_q   <= in_alu_result;
        st_q    <= in_st_data;
      end
      if (resp_hs) ld_data_q <= ld_ext;
    end
  end

  // request and write-back outputs drop in the reset cycle itself
  always_comb begin
    in_ready      = (state == IDLE);
    busy          = (state != IDLE);
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    gpr_we        = 1'b0;
    gpr_waddr     = '0;
    gpr_wdata     = '0;
    commit        = 1'b0;
    mem_err       = 1'b0;
    if ((state == MREQ) && !rst) begin
      mem_req_valid = 1'b1;
      mem_req_we    = store_q;
      mem_req_addr  = alu_q;
      mem_req_wdata = st_q;
    end
    if ((state == WB) && !rst) begin
      gpr_we    = wb_en_q && !store_q && (rd_q != '0) && !to_flag;
      gpr_waddr = rd_q;
      gpr_wdata = load_q ? ld_data_q : alu_q;
      commit    = 1'b1;
      mem_err   = to_flag;
    end
  end

endmodule

// File: doc/exu_wb_ctrl.md
Name: exu_wb_ctrl

Overview:
Multi-cycle execute/write-back sequencer that owns the GPR write port. It accepts one decoded instruction at a time and, for loads and stores, issues a single memory request with a valid/ready handshake. It extends load data by access size and drives exactly one GPR write per instruction, then pulses commit. It sits between decode/ALU and the register file and replaces the combinational write-back select.

Parameters:
ISA_WIDTH, 32, datapath width (32 or 64)
GPR_ADDR_WIDTH, 5, register index width
TIMEOUT_CYCLES, 255, memory wait limit; used only with the optional feature

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  decoded instruction available
in_ready  out  1  controller can accept an instruction
in_wb_en  in  1  instruction writes rd
in_rd  in  GPR_ADDR_WIDTH  destination register
in_mem_r  in  1  instruction is a load
in_mem_w  in  1  instruction is a store
in_ld_size  in  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu, 011 ld, 110 lwu
in_alu_result  in  ISA_WIDTH  ALU result, or effective address for memory ops
in_st_data  in  ISA_WIDTH  store data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts the request
mem_req_we  out  1  1 = store
mem_req_addr  out  ISA_WIDTH  request address
mem_req_wdata  out  ISA_WIDTH  store data
mem_resp_valid  in  1  load data valid
mem_resp_rdata  in  ISA_WIDTH  load data
gpr_we  out  1  GPR write enable
gpr_waddr  out  GPR_ADDR_WIDTH  GPR write index
gpr_wdata  out  ISA_WIDTH  GPR write data
commit  out  1  one-cycle pulse per retired instruction
mem_err  out  1  one-cycle pulse on memory timeout
busy  out  1  state is not IDLE

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- States: IDLE, MREQ, MRESP, WB. Reset drives state to IDLE and clears all latched fields and the timeout counter.
- Outputs after reset: in_ready=1; all other outputs 0.
- in_ready is 1 exactly when state is IDLE. In the reset cycle itself, input is ignored.
- Accept:
  - Acceptance happens when in_valid & in_ready. All in_* fields are latched.
  - If in_mem_r or in_mem_w, go to MREQ; otherwise go to WB.
  - If in_mem_r and in_mem_w are both 1, treat as a load.
- MREQ:
  - mem_req_valid=1. addr, wdata and we come from latched values and stay stable until mem_req_ready.
  - On ready: a store goes to WB, a load goes to MRESP.
- MRESP:
  - Wait for mem_resp_valid. Capture extended data, then go to WB.
  - mem_resp_valid in any other state is ignored.
- Load extension:
  - lb/lh/lw: sign-extend bits 7/15/31 to ISA_WIDTH.
  - lbu/lhu/lwu: zero-extend.
  - ld: full data (64-bit only).
  - Reserved encodings, and ld/lwu when ISA_WIDTH=32: write data is 0.
- WB (lasts exactly one cycle):
  - gpr_we = latched wb_en & ~store & (rd != 0).
  - gpr_waddr = rd.
  - gpr_wdata = load data for loads, latched alu_result otherwise.
  - commit=1. Next state is IDLE.
- Outside WB: gpr_we=0, commit=0, gpr_waddr=0, gpr_wdata=0.
- Latency (accept at cycle N):
  - Non-memory instruction: WB at N+1.
  - Load with ready at N+1 and response at N+2: WB at N+3.
  - Store with ready at N+1: WB at N+2.
- Back-to-back: IDLE follows WB, so maximum throughput is one instruction per 2 cycles.
- Reset mid-operation: return to IDLE immediately. No gpr_we or commit is produced for the aborted instruction. A pending mem_req_valid deasserts in the reset cycle.

Optional Feature:
GPR_WB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to MREQ and increments each cycle spent in MREQ or MRESP.
  - When the count reaches TIMEOUT_CYCLES without a handshake, go to WB with gpr_we forced to 0.
  - mem_err pulses 1 in that WB cycle; commit still pulses.
- Undefined: the controller waits indefinitely and mem_err is tied to 0.

Test Plan:
- Reset then addi (wb_en=1, rd=5, alu_result=0x0000_0010) -> at accept+1: gpr_we=1, waddr=5, wdata=0x10, commit=1; in_ready back to 1 the next cycle.
- ALU op with rd=0, alu_result=0xDEAD_BEEF -> gpr_we=0 and commit=1 in the WB cycle.
- lb, addr 0x8000_0000, ready delayed 3 cycles, rdata=0x0000_0080 -> mem_req_valid held for 4 cycles with stable addr; then gpr_wdata=0xFFFF_FF80. Repeat with lbu -> 0x0000_0080.
- sw, addr 0x8000_0004, st_data=0x1234_5678 -> mem_req_we=1, wdata=0x1234_5678; WB cycle with gpr_we=0, commit=1.
- Load whose response never arrives, with rst asserted in MRESP -> next cycle: IDLE, in_ready=1, no commit, no gpr_we.
- With GPR_WB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_req_ready held 0 -> mem_err=1 and commit=1 after 8 wait cycles, gpr_we=0. Without the macro: still waiting after 100 cycles, mem_err=0.
